// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode/state types and default sizes for the ALU writeback sequencer
package alu_seq_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NOT  = 3'd5,
        OP_SHL  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_writeback_sequencer_if.sv
// rtl/alu_writeback_sequencer_if.sv - instruction handshake plus cache state/write bus
// Flag outputs exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_writeback_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int SEL_W = 3
);
    logic                   instr_valid;
    logic                   instr_ready;
    logic [2:0]             op;
    logic [SEL_W-1:0]       src_a;
    logic [SEL_W-1:0]       src_b;
    logic [SEL_W-1:0]       dst;
    logic [DEPTH*WIDTH-1:0] mem_state;
    logic [DEPTH-1:0]       wr_onehot;
    logic [WIDTH-1:0]       wr_data;
    logic                   done;
`ifdef ALU_SEQ_FLAGS_EN
    logic                   flag_zero;
    logic                   flag_carry;

    modport master (
        output instr_valid, op, src_a, src_b, dst, mem_state,
        input  instr_ready, wr_onehot, wr_data, done, flag_zero, flag_carry
    );

    modport slave (
        input  instr_valid, op, src_a, src_b, dst, mem_state,
        output instr_ready, wr_onehot, wr_data, done, flag_zero, flag_carry
    );
`else
    modport master (
        output instr_valid, op, src_a, src_b, dst, mem_state,
        input  instr_ready, wr_onehot, wr_data, done
    );

    modport slave (
        input  instr_valid, op, src_a, src_b, dst, mem_state,
        output instr_ready, wr_onehot, wr_data, done
    );
`endif
endinterface

// File: rtl/alu_core_16.sv
// rtl/alu_core_16.sv - combinational ALU: (op, a, b) -> (result, carry)
module alu_core_16
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Top bit of the widened difference is the unsigned borrow (A < B).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_carry  = w_diff[WIDTH];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOT:  o_result = ~i_a;
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                o_carry  = i_a[WIDTH-1];
            end
            OP_PASS: o_result = i_a;
            default: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/alu_writeback_sequencer.sv
// rtl/alu_writeback_sequencer.sv - one-at-a-time read/execute/writeback against the register cache
// Optional zero/carry flag outputs are enabled by ALU_SEQ_FLAGS_EN.
module alu_writeback_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int SEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_writeback_sequencer_if.slave  bus
);

    seq_state_e       r_state;
    seq_state_e       w_next_state;
    alu_op_e          r_op;
    logic [SEL_W-1:0] r_src_a;
    logic [SEL_W-1:0] r_src_b;
    logic [SEL_W-1:0] r_dst;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_wr_data;

    logic [WIDTH-1:0] w_words [DEPTH];
    logic             w_ready;
    logic             w_done;
    logic             w_accept;
    logic [DEPTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_words[i] = bus.mem_state[i*WIDTH +: WIDTH];
        end
    end

    assign w_accept = bus.instr_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Select is decoded from state so it can only ever be high in WRITE.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_onehot     = '0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ:  w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = ST_WRITE;
            ST_WRITE: begin
                w_onehot     = {{(DEPTH-1){1'b0}}, 1'b1} << r_dst;
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_ADD;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_dst     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= alu_op_e'(bus.op);
                r_src_a <= bus.src_a;
                r_src_b <= bus.src_b;
                r_dst   <= bus.dst;
            end
            // Operands are captured before any write, so src == dst is safe.
            if (r_state == ST_READ) begin
                r_op_a <= w_words[r_src_a];
                r_op_b <= w_words[r_src_b];
            end
            if (r_state == ST_EXEC) begin
                r_wr_data <= w_alu_result;
            end
        end
    end

    alu_core_16 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

`ifdef ALU_SEQ_FLAGS_EN
    logic r_flag_zero;
    logic r_flag_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_flag_zero  <= (w_alu_result == '0);
            r_flag_carry <= w_alu_carry;
        end
    end

    assign bus.flag_zero  = r_flag_zero;
    assign bus.flag_carry = r_flag_carry;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_alu_carry;
`endif

    assign bus.instr_ready = w_ready;
    assign bus.wr_onehot   = w_onehot;
    assign bus.wr_data     = r_wr_data;
    assign bus.done        = w_done;

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// tb/tb_alu_writeback_sequencer.sv - directed bench with cache model and per-cycle scoreboard
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_writeback_sequencer;
    import alu_seq_pkg::*;

    localparam int W = 16;
    localparam int D = 8;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } preload_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_writeback_sequencer_if #(.WIDTH(W), .DEPTH(D), .SEL_W(3)) bus ();

    alu_writeback_sequencer #(.WIDTH(W), .DEPTH(D), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] cache [D];
    logic [15:0] mregs [D];
    preload_t    pl_q [$];

    int total = 0;
    int bad   = 0;

    always_comb begin
        for (int i = 0; i < D; i++) begin
            bus.mem_state[i*W +: W] = cache[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] model_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        int ai = int'(a);
        int bi = int'(b);
        int r  = 0;
        bit c  = 1'b0;
        case (op)
            0: begin r = ai + bi; c = (r > 65535); end
            1: begin r = ai - bi; c = (ai < bi); end
            2: r = ai & bi;
            3: r = ai | bi;
            4: r = ai ^ bi;
            5: r = ~ai;
            6: begin r = ai * 2; c = (ai >= 32768); end
            default: r = ai;
        endcase
        return {c, r[15:0]};
    endfunction

    // Scoreboard: cnt counts cycles since accept (0 = idle, 3 = write cycle).
    int          cnt = 0;
    bit          armed = 1'b0;
    int          p_dst = 0;
    logic [15:0] p_res = '0;
    logic        p_c = 1'b0;
    logic [15:0] exp_wd = '0;
    logic        exp_fz = 1'b0;
    logic        exp_fc = 1'b0;

    always @(negedge clk) begin
        logic [16:0] m;
        while (pl_q.size() > 0) begin
            preload_t e;
            e = pl_q.pop_front();
            cache[e.idx] = e.val;
            mregs[e.idx] = e.val;
        end
        if (armed) begin
            chk("sb_ready",  32'(bus.instr_ready), 32'(cnt == 0));
            chk("sb_onehot", 32'(bus.wr_onehot), (cnt == 3) ? (32'h1 << p_dst) : 32'h0);
            chk("sb_done",   32'(bus.done), 32'(cnt == 3));
            chk("sb_wr_data", 32'(bus.wr_data), 32'(exp_wd));
`ifdef ALU_SEQ_FLAGS_EN
            chk("sb_flag_zero",  32'(bus.flag_zero), 32'(exp_fz));
            chk("sb_flag_carry", 32'(bus.flag_carry), 32'(exp_fc));
`endif
        end
        for (int i = 0; i < D; i++) begin
            if (bus.wr_onehot[i] === 1'b1) cache[i] = bus.wr_data;
        end
        if (cnt == 3) mregs[p_dst] = p_res;
        if (rst) begin
            cnt    = 0;
            exp_wd = '0;
            exp_fz = 1'b0;
            exp_fc = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            if (cnt == 0) begin
                if (bus.instr_valid) begin
                    m     = model_alu(int'(bus.op), mregs[bus.src_a], mregs[bus.src_b]);
                    p_res = m[15:0];
                    p_c   = m[16];
                    p_dst = int'(bus.dst);
                    cnt   = 1;
                end
            end else if (cnt == 3) begin
                cnt = 0;
            end else begin
                if (cnt == 2) begin
                    exp_wd = p_res;
                    exp_fz = (p_res == 16'h0);
                    exp_fc = p_c;
                end
                cnt++;
            end
        end
    end

    task automatic preload(input int idx, input logic [15:0] val);
        preload_t e;
        e.idx = idx;
        e.val = val;
        pl_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int op, input int a, input int b, input int d);
        bus.op          = 3'(op);
        bus.src_a       = 3'(a);
        bus.src_b       = 3'(b);
        bus.dst         = 3'(d);
        bus.instr_valid = 1'b1;
    endtask

    // Returns the number of edges from entry up to and including the accepting edge.
    task automatic accept_wait(output int cyc);
        logic r;
        cyc = 0;
        r   = 1'b0;
        while (!r && cyc < 20) begin
            @(negedge clk);
            r = bus.instr_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!r) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=%0d cycles required=accept", cyc);
        end
    endtask

    task automatic run_check(input int op, input int a, input int b, input int d,
                             input logic [15:0] exp_data, input logic [7:0] exp_oh);
        int c;
        set_instr(op, a, b, d);
        accept_wait(c);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("lat_read_done", 32'(bus.done), 32'h0);
        chk("lat_read_ready", 32'(bus.instr_ready), 32'h0);
        @(negedge clk);
        chk("lat_exec_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        chk("wr_done", 32'(bus.done), 32'h1);
        chk("wr_onehot", 32'(bus.wr_onehot), 32'(exp_oh));
        chk("wr_data", 32'(bus.wr_data), 32'(exp_data));
        @(negedge clk);
        chk("post_done", 32'(bus.done), 32'h0);
        chk("post_onehot", 32'(bus.wr_onehot), 32'h0);
        chk("post_ready", 32'(bus.instr_ready), 32'h1);
        chk("post_wr_data_hold", 32'(bus.wr_data), 32'(exp_data));
        @(posedge clk);
        #1;
    endtask

    logic [15:0] op_tbl [8];

    initial begin
        int c;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.op          = '0;
        bus.src_a       = '0;
        bus.src_b       = '0;
        bus.dst         = '0;
        for (int i = 0; i < D; i++) begin
            preload_t e;
            e.idx = i;
            e.val = 16'h0;
            pl_q.push_back(e);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (10) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.instr_ready), 32'h1);
            chk("idle_onehot", 32'(bus.wr_onehot), 32'h0);
            chk("idle_wr_data", 32'(bus.wr_data), 32'h0);
            chk("idle_done", 32'(bus.done), 32'h0);
        end
        @(posedge clk);
        #1;

        preload(1, 16'd5);
        preload(2, 16'd3);
        run_check(0, 1, 2, 4, 16'd8, 8'h10);
        chk("add_cache_r4", 32'(cache[4]), 32'd8);

        preload(1, 16'd3);
        preload(2, 16'd5);
        run_check(1, 1, 2, 0, 16'hFFFE, 8'h01);
        chk("sub_cache_r0", 32'(cache[0]), 32'hFFFE);
`ifdef ALU_SEQ_FLAGS_EN
        chk("sub_flag_carry", 32'(bus.flag_carry), 32'h1);
        chk("sub_flag_zero", 32'(bus.flag_zero), 32'h0);
`endif

        op_tbl[0] = 16'h80F4;
        op_tbl[1] = 16'h7F0E;
        op_tbl[2] = 16'h0001;
        op_tbl[3] = 16'h80F3;
        op_tbl[4] = 16'h80F2;
        op_tbl[5] = 16'h7FFE;
        op_tbl[6] = 16'h0002;
        op_tbl[7] = 16'h8001;
        preload(6, 16'h8001);
        preload(7, 16'h00F3);
        for (int k = 0; k < 8; k++) begin
            run_check(k, 6, 7, 0, op_tbl[k], 8'h01);
        end

        preload(3, 16'hFFFF);
        set_instr(0, 3, 3, 3);
        accept_wait(c);
        set_instr(4, 3, 3, 5);
        accept_wait(c);
        chk("held_valid_gap", 32'(c), 32'd4);
        bus.instr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("self_add_r3", 32'(cache[3]), 32'hFFFE);
        chk("xor_after_r5", 32'(cache[5]), 32'h0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("xor_flag_zero", 32'(bus.flag_zero), 32'h1);
`endif

        preload(0, 16'h1234);
        preload(1, 16'h0);
        preload(2, 16'h0);
        set_instr(7, 0, 0, 1);
        accept_wait(c);
        set_instr(7, 1, 1, 2);
        accept_wait(c);
        chk("b2b_gap", 32'(c), 32'd4);
        bus.instr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pass_r1", 32'(cache[1]), 32'h1234);
        chk("pass_r2", 32'(cache[2]), 32'h1234);

        preload(1, 16'd7);
        preload(2, 16'd9);
        preload(4, 16'hAAAA);
        set_instr(0, 1, 2, 4);
        accept_wait(c);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_onehot", 32'(bus.wr_onehot), 32'h0);
        chk("rst_exec_done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", 32'(bus.instr_ready), 32'h1);
        chk("rst_after_wr_data", 32'(bus.wr_data), 32'h0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_onehot", 32'(bus.wr_onehot), 32'h0);
            chk("rst_no_done", 32'(bus.done), 32'h0);
        end
        chk("rst_cache_r4", 32'(cache[4]), 32'hAAAA);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
